fetch_unit: RTL and testbench

- PC-side consumer of the next-PC logic. Holds the architectural fetch PC and issues sequential instruction-memory requests through a valid/ready handshake.
- Buffers returned instructions in an in-order queue and hands each instruction to decode together with its PC+4. That PC+4 is the value the next-PC logic consumes.
- Applies branch, jump, jal and jr redirects by reloading the PC and squashing all wrong-path fetches.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: redirect input, imem request/response channels, decode handshake.
// Latency: none, wires only.
// Backpressure: carries imem_req_ready and inst_ready back to the fetch unit.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pcplus4;
  logic [31:0] fetch_pc;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pcplus4, fetch_pc
  );

  // Memory / next-PC / decode side
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pcplus4, fetch_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: holds the fetch PC, issues sequential imem requests, queues returned words with PC+4.
// Latency: response to inst 1 cycle through the queue (0 cycles on the FETCH_BYPASS_EN bypass path).
// Backpressure: issue credit bounds live+squash by MAX_OUTSTANDING and live+count by FIFO_DEPTH; inst_ready stalls the queue.
// Optional macro FETCH_BYPASS_EN: a response into an empty, unsquashed queue is presented combinationally.

// Generic synchronous FIFO with flush; caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointer increment that also handles non power-of-two depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign head_dat = mem[rd_ptr];

  // Storage write; data array needs no reset, occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_vld) - CW'(pop_vld);
    end
  end
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QCW  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pcplus4;
  } inst_ent_t;

  logic [31:0]     pc_q;
  logic [31:0]     pc_plus4;
  logic [31:0]     redirect_aligned;
  logic [CNTW-1:0] live_q;     // accepted requests whose response is still wanted
  logic [CNTW-1:0] squash_q;   // accepted requests whose response will be dropped

  logic            req_vld;
  logic            fire;
  logic            resp;
  logic            resp_squash;
  logic            resp_live;
  logic            bypass_hit;

  logic            q_push;
  logic            q_pop;
  logic            q_empty;
  inst_ent_t       q_push_dat;
  inst_ent_t       q_head;
  logic [QCW-1:0]  q_count;

  logic            tag_pop;
  logic [31:0]     tag_head;
  logic [CNTW-1:0] tag_count;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = bus.redirect_pc & ~32'h3;
  assign q_empty          = (q_count == '0);

  assign bus.fetch_pc  = pc_q;
  assign bus.imem_addr = pc_q;

  // Issue credit, response classification and queue control.
  always_comb begin
    req_vld = rst_n && !bus.redirect_valid
              && (int'(live_q) + int'(squash_q) < MAX_OUTSTANDING)
              && (int'(live_q) + int'(q_count) < FIFO_DEPTH);
    fire = req_vld && bus.imem_req_ready;

    // Squashed responses are always older than live ones, so drain squash first.
    resp        = rst_n && bus.imem_resp_valid;
    resp_squash = resp && (squash_q != '0);
    resp_live   = resp && (squash_q == '0) && (live_q != '0);

    bypass_hit = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_hit = resp_live && !bus.redirect_valid && q_empty;
`endif

    tag_pop    = resp_live && !bus.redirect_valid;
    q_pop      = !q_empty && bus.inst_ready;
    q_push     = tag_pop && !(bypass_hit && bus.inst_ready);
    q_push_dat = '{word: bus.imem_resp_data, pcplus4: tag_head};
  end

  // Decode-facing outputs: queue head, else bypassed response, else zero.
  always_comb begin
    bus.imem_req_valid = req_vld;
    bus.inst_valid     = rst_n && (!q_empty || bypass_hit);
    bus.inst           = 32'h0;
    bus.inst_pcplus4   = 32'h0;
    if (!q_empty) begin
      bus.inst         = q_head.word;
      bus.inst_pcplus4 = q_head.pcplus4;
    end else if (bypass_hit) begin
      bus.inst         = bus.imem_resp_data;
      bus.inst_pcplus4 = tag_head;
    end
  end

  // Fetch PC and in-flight accounting; a redirect turns every live request into a squashed one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      live_q   <= '0;
      squash_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q     <= redirect_aligned;
      live_q   <= '0;
      squash_q <= squash_q + live_q - CNTW'(resp_squash || resp_live);
    end else begin
      if (fire) pc_q <= pc_plus4;
      live_q   <= live_q + CNTW'(fire) - CNTW'(resp_live);
      squash_q <= squash_q - CNTW'(resp_squash);
    end
  end

  // PC+4 of every live request, consumed in order as responses return.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_valid),
    .push_vld (fire),
    .push_dat (pc_plus4),
    .pop_vld  (tag_pop),
    .head_dat (tag_head),
    .count    (tag_count)
  );

  // Instruction queue towards decode.
  sync_fifo #(
    .WIDTH ($bits(inst_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_valid),
    .push_vld (q_push),
    .push_dat (q_push_dat),
    .pop_vld  (q_pop),
    .head_dat (q_head),
    .count    (q_count)
  );

  // Memory must never answer a request that was not accepted.
  a_resp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_resp_valid |-> (live_q != '0 || squash_q != '0));

  // Every live request owns exactly one tag.
  a_tag_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == live_q);
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          MAXO     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted request in order, flagged dead once redirected;
  // a queue of words waiting for decode; the memory's pending responses.
  typedef struct {
    logic [31:0] pcp4;
    bit          dead;
  } out_t;

  out_t        outq[$];
  logic [31:0] mq_w[$];
  logic [31:0] mq_p[$];
  int          mem_due[$];
  logic [31:0] mem_dat[$];
  logic [31:0] mpc;
  logic [31:0] dctr;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Observed DUT traffic for the directed checks.
  logic [31:0] got_a[$];
  logic [31:0] got_i[$];
  logic [31:0] got_p[$];

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_clear();
    outq.delete();
    mq_w.delete();
    mq_p.delete();
    mem_due.delete();
    mem_dat.delete();
    mpc      = RESET_PC;
    dctr     = 32'h1111_0000;
    last_due = cyc;
  endtask

  task automatic drive_idle();
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_ready      = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, advance the model.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit irdy);
    bit          resp, deliver, bhit, exp_req, exp_iv;
    logic [31:0] rdat, exp_i, exp_p, nxt;
    int          nlive, due, lat;
    out_t        o;
    @(negedge clk);
    resp = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    rdat = resp ? mem_dat[0] : 32'h0;
    o    = '{pcp4: 32'h0, dead: 1'b1};
    if (resp) o = outq[0];
    bus.redirect_valid  = rv;
    bus.redirect_pc     = rpc;
    bus.imem_req_ready  = rdy;
    bus.inst_ready      = irdy;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = rdat;
    #1;
    nlive = 0;
    foreach (outq[i]) if (!outq[i].dead) nlive++;
    exp_req = !rv && (outq.size() < MAXO) && (nlive + mq_w.size() < DEPTH);
    deliver = resp && !rv && !o.dead;
    bhit    = 1'b0;
`ifdef FETCH_BYPASS_EN
    bhit = deliver && (mq_w.size() == 0);
`endif
    exp_iv = (mq_w.size() > 0) || bhit;
    if (mq_w.size() > 0) begin
      exp_i = mq_w[0];
      exp_p = mq_p[0];
    end else if (bhit) begin
      exp_i = rdat;
      exp_p = o.pcp4;
    end else begin
      exp_i = 32'h0;
      exp_p = 32'h0;
    end
    chk("req_valid", bus.imem_req_valid, exp_req);
    chk("fetch_pc", bus.fetch_pc, mpc);
    if (exp_req) chk("imem_addr", bus.imem_addr, mpc);
    chk("inst_valid", bus.inst_valid, exp_iv);
    chk("inst", bus.inst, exp_i);
    chk("inst_pcplus4", bus.inst_pcplus4, exp_p);

    if (bus.imem_req_valid && rdy) got_a.push_back(bus.imem_addr);
    if (bus.inst_valid && irdy && !rv) begin
      got_i.push_back(bus.inst);
      got_p.push_back(bus.inst_pcplus4);
    end

    if (resp) begin
      void'(outq.pop_front());
      void'(mem_due.pop_front());
      void'(mem_dat.pop_front());
    end
    if (irdy && mq_w.size() > 0) begin
      void'(mq_w.pop_front());
      void'(mq_p.pop_front());
    end else if (irdy && bhit) begin
      deliver = 1'b0;
    end
    if (rv) begin
      mq_w.delete();
      mq_p.delete();
      foreach (outq[i]) outq[i].dead = 1'b1;
      mpc = rpc & ~32'h3;
    end else begin
      if (deliver) begin
        mq_w.push_back(rdat);
        mq_p.push_back(o.pcp4);
      end
      if (exp_req && rdy) begin
        nxt = mpc + 32'd4;
        outq.push_back('{pcp4: nxt, dead: 1'b0});
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_due.push_back(due);
        mem_dat.push_back(dctr);
        dctr = dctr + 32'd1;
        mpc  = nxt;
      end
    end
    cyc++;
  endtask

  initial begin
    int na, np;
    drive_idle();
    model_clear();

    // Outputs while held in reset
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_fetch_pc", bus.fetch_pc, RESET_PC);
    chk("rst_inst", bus.inst, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic stream: 1-cycle memory, decode always ready
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("b_addr0", qget(got_a, 0), 32'h0000_0000);
    chk("b_addr1", qget(got_a, 1), 32'h0000_0004);
    chk("b_addr2", qget(got_a, 2), 32'h0000_0008);
    chk("b_inst0", qget(got_i, 0), 32'h1111_0000);
    chk("b_pcp4_0", qget(got_p, 0), 32'h0000_0004);
    chk("b_inst1", qget(got_i, 1), 32'h1111_0001);
    chk("b_pcp4_1", qget(got_p, 1), 32'h0000_0008);

    // Build a pending request with one queued word, then reset asynchronously
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("c_pre_req_valid", bus.imem_req_valid, 1'b1);
    chk("c_pre_inst_valid", bus.inst_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("c_req_valid", bus.imem_req_valid, 1'b0);
    chk("c_inst_valid", bus.inst_valid, 1'b0);
    chk("c_inst", bus.inst, 32'h0);
    chk("c_pcp4", bus.inst_pcplus4, 32'h0);
    chk("c_fetch_pc", bus.fetch_pc, RESET_PC);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Decode stalled: credit stops issue at queue depth
    na = got_a.size();
    np = got_p.size();
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("d_fires", got_a.size() - na, DEPTH);
    for (int k = 0; k < 12; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("d_pcp4_0", qget(got_p, np), 32'h0000_0004);
    chk("d_pcp4_1", qget(got_p, np + 1), 32'h0000_0008);
    chk("d_pcp4_2", qget(got_p, np + 2), 32'h0000_000C);

    // 3-cycle memory, redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && outq.size() < 2; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    na = got_a.size();
    np = got_p.size();
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("e_addr", qget(got_a, na), 32'h0000_0100);
    chk("e_pcp4", qget(got_p, np), 32'h0000_0104);

    // Redirect coinciding with a response and a queue pop
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 40; k++) begin
      if (mem_due.size() > 0 && mem_due[0] <= cyc && mq_w.size() > 0) begin
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        break;
      end
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // PC wrap at the top of the address space
    na = got_a.size();
    np = got_p.size();
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("g_addr_top", qget(got_a, na), 32'hFFFF_FFFC);
    chk("g_addr_wrap", qget(got_a, na + 1), 32'h0000_0000);
    chk("g_pcp4_wrap", qget(got_p, np), 32'h0000_0000);

    // Randomized traffic against the model
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(15, 0) == 0), $urandom,
           ($urandom_range(3, 0) != 0), ($urandom_range(1, 0) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
